// File: rtl/axis_line_packer_if.sv
// Stream-in / line-write-out bundle for axis_line_packer.
// slave = packer side, master = FIFO/ring side driving beats and accepting writes.
interface axis_line_packer_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 16,
  parameter int ADDR_WIDTH     = 64
);
  logic [DATA_WIDTH-1:0]                      s_axis_tdata;
  logic                                       s_axis_tvalid;
  logic                                       s_axis_tready;
  logic                                       wr_valid;
  logic                                       wr_ready;
  logic [ADDR_WIDTH-1:0]                      wr_addr;
  logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0]  wr_data;
  logic [WORDS_PER_LINE-1:0]                  wr_wen;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, wr_ready,
    output s_axis_tready, wr_valid, wr_addr, wr_data, wr_wen
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, wr_ready,
    input  s_axis_tready, wr_valid, wr_addr, wr_data, wr_wen
  );
endinterface

// File: rtl/axis_line_packer.sv
// Packs 32-bit stream beats into lines and writes them to a host ring buffer.
// Optional idle auto-flush: define AXIS_LINE_PACKER_TIMEOUT_FLUSH_EN.
module axis_line_packer #(
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 16,
  parameter int ADDR_WIDTH     = 64,
  parameter int FLUSH_TIMEOUT  = 1024
) (
  input  logic                   s_axis_aclk,
  input  logic                   s_axis_aresetn,
  axis_line_packer_if.slave      bus,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [15:0]            ring_lines,
  input  logic                   flush,
  output logic [31:0]            lines_written
);

  localparam int IDX_W      = $clog2(WORDS_PER_LINE);
  localparam int LINE_BYTES = WORDS_PER_LINE * DATA_WIDTH / 8;

  generate
    if (WORDS_PER_LINE < 2 || (WORDS_PER_LINE & (WORDS_PER_LINE - 1)) != 0 ||
        FLUSH_TIMEOUT < 2) begin : g_bad_cfg
      $error("axis_line_packer: bad WORDS_PER_LINE or FLUSH_TIMEOUT");
    end
  endgenerate

  typedef enum logic {S_FILL, S_ISSUE} state_t;

  // Reset asserts asynchronously, releases on the clock.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) r_rst_sync <= 2'b00;
    else                 r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  state_t                                     r_state, w_state_nxt;
  logic [IDX_W-1:0]                           r_word_idx;
  logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0]  r_buf;
  logic [WORDS_PER_LINE-1:0]                  r_wen;
  logic [15:0]                                r_wr_ptr;
  logic [ADDR_WIDTH-1:0]                      r_addr;
  logic [31:0]                                r_lines;

  logic w_acc, w_hs, w_last, w_issue_go, w_timeout;

  assign w_acc  = bus.s_axis_tvalid & bus.s_axis_tready;
  assign w_hs   = (r_state == S_ISSUE) & bus.wr_ready;
  assign w_last = w_acc && (r_word_idx == IDX_W'(WORDS_PER_LINE - 1));

`ifdef AXIS_LINE_PACKER_TIMEOUT_FLUSH_EN
  localparam int TW = $clog2(FLUSH_TIMEOUT);
  logic [TW-1:0] r_timer;
  logic          w_idle;

  assign w_idle    = (r_state == S_FILL) && (r_word_idx != '0) && !w_acc;
  assign w_timeout = w_idle && (r_timer == TW'(FLUSH_TIMEOUT - 1));

  always_ff @(posedge s_axis_aclk or negedge w_rst_n) begin
    if (!w_rst_n)                  r_timer <= '0;
    else if (w_idle && !w_timeout) r_timer <= r_timer + TW'(1);
    else                           r_timer <= '0;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge s_axis_aclk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_FILL;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue_go  = 1'b0;
    case (r_state)
      S_FILL: begin
        // A coincident beat counts toward "non-empty", so flush never drops it.
        if (w_last || w_timeout || (flush && ((r_word_idx != '0) || w_acc))) begin
          w_state_nxt = S_ISSUE;
          w_issue_go  = 1'b1;
        end
      end
      S_ISSUE: begin
        if (bus.wr_ready) w_state_nxt = S_FILL;
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_buf      <= '0;
      r_wen      <= '0;
      r_word_idx <= '0;
    end else if (w_hs) begin
      r_buf      <= '0;
      r_wen      <= '0;
      r_word_idx <= '0;
    end else if (w_acc) begin
      for (int k = 0; k < WORDS_PER_LINE; k++) begin
        if (r_word_idx == IDX_W'(k)) begin
          r_buf[k] <= bus.s_axis_tdata;
          r_wen[k] <= 1'b1;
        end
      end
      r_word_idx <= r_word_idx + IDX_W'(1);
    end
  end

  // Address is captured on entry to ISSUE so it holds while wr_ready is low.
  always_ff @(posedge s_axis_aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_addr   <= '0;
      r_wr_ptr <= '0;
      r_lines  <= '0;
    end else begin
      if (w_issue_go)
        r_addr <= base_addr + ADDR_WIDTH'(r_wr_ptr) * ADDR_WIDTH'(LINE_BYTES);
      if (w_hs) begin
        r_lines <= r_lines + 32'd1;
        if (ring_lines <= 16'd1 || r_wr_ptr >= ring_lines - 16'd1) r_wr_ptr <= '0;
        else                                                      r_wr_ptr <= r_wr_ptr + 16'd1;
      end
    end
  end

  assign bus.s_axis_tready = w_rst_n && (r_state == S_FILL);
  assign bus.wr_valid      = (r_state == S_ISSUE);
  assign bus.wr_addr       = r_addr;
  assign bus.wr_data       = r_buf;
  assign bus.wr_wen        = r_wen;
  assign lines_written     = r_lines;

endmodule
